// File: rtl/uart_fifo_peripheral.sv
// uart_fifo_peripheral: memory-mapped UART with TX/RX FIFOs, sticky error
// status, loopback and a level interrupt, on a req/gnt/rvalid slave port.
// Ports: clk, reset (async, active low); slave_data_* bus (addr/we/be/wdata
// in, rdata/rvalid/gnt out) with data_req_i; rxd_uart in, txd_uart out
// (idle high); irq_o registered level interrupt.
// axi_uart: 8N1 serial engine with AXI-stream byte ports. One bit lasts
// prescale*8 clocks. rst is asynchronous, active high.

module axi_uart (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  input  logic        rxd,
  output logic        txd,
  output logic        tx_busy,
  output logic        rx_busy,
  output logic        rx_overrun_error,
  output logic        rx_frame_error,
  input  logic [15:0] prescale
);
  logic [18:0] bit_len;
  logic [8:0]  tx_sh_q, tx_sh_d;
  logic [3:0]  tx_bits_q, tx_bits_d, rx_bits_q, rx_bits_d;
  logic [18:0] tx_tmr_q, tx_tmr_d, rx_tmr_q, rx_tmr_d;
  logic        txd_q, txd_d, m_valid_q, m_valid_d, ovr_q, ovr_d, ferr_q, ferr_d;
  logic [1:0]  rxd_sync_q;
  logic [7:0]  rx_sh_q, rx_sh_d, m_data_q, m_data_d;
  logic        rx_s;

  // prescale 0 would give a zero-length bit; clamp to one prescale unit
  assign bit_len = (prescale == 16'd0) ? 19'd8 : {prescale, 3'b000};
  assign rx_s    = rxd_sync_q[1];

  assign tx_busy          = (tx_bits_q != 4'd0) || (tx_tmr_q != 19'd0);
  assign s_axis_tready    = !tx_busy;
  assign txd              = txd_q;
  assign rx_busy          = (rx_bits_q != 4'd0);
  assign m_axis_tdata     = m_data_q;
  assign m_axis_tvalid    = m_valid_q;
  assign rx_overrun_error = ovr_q;
  assign rx_frame_error   = ferr_q;

  // TX: start bit goes out on load, then 8 data bits and the stop bit are
  // shifted from tx_sh, each held for one bit time.
  always_comb begin
    tx_sh_d   = tx_sh_q;
    tx_bits_d = tx_bits_q;
    tx_tmr_d  = tx_tmr_q;
    txd_d     = txd_q;
    if (s_axis_tvalid && s_axis_tready) begin
      txd_d     = 1'b0;
      tx_sh_d   = {1'b1, s_axis_tdata};
      tx_bits_d = 4'd9;
      tx_tmr_d  = bit_len - 19'd1;
    end else if (tx_tmr_q != 19'd0) begin
      tx_tmr_d = tx_tmr_q - 19'd1;
    end else if (tx_bits_q != 4'd0) begin
      txd_d     = tx_sh_q[0];
      tx_sh_d   = {1'b1, tx_sh_q[8:1]};
      tx_bits_d = tx_bits_q - 4'd1;
      tx_tmr_d  = bit_len - 19'd1;
    end
  end

  // RX: on a falling edge wait half a bit, then sample start (10), 8 data
  // bits and stop (1) at bit centres.
  always_comb begin
    rx_bits_d = rx_bits_q;
    rx_tmr_d  = rx_tmr_q;
    rx_sh_d   = rx_sh_q;
    m_data_d  = m_data_q;
    m_valid_d = m_valid_q & ~m_axis_tready;
    ovr_d     = 1'b0;
    ferr_d    = 1'b0;
    if (rx_bits_q == 4'd0) begin
      if (!rx_s) begin
        rx_bits_d = 4'd10;
        rx_tmr_d  = {1'b0, bit_len[18:1]} - 19'd1;
      end
    end else if (rx_tmr_q != 19'd0) begin
      rx_tmr_d = rx_tmr_q - 19'd1;
    end else begin
      rx_tmr_d  = bit_len - 19'd1;
      rx_bits_d = rx_bits_q - 4'd1;
      if (rx_bits_q == 4'd10) begin
        if (rx_s) rx_bits_d = 4'd0;  // glitch, not a start bit
      end else if (rx_bits_q == 4'd1) begin
        if (rx_s) begin
          m_data_d  = rx_sh_q;
          m_valid_d = 1'b1;
          ovr_d     = m_valid_q & ~m_axis_tready;
        end else begin
          ferr_d = 1'b1;
        end
      end else begin
        rx_sh_d = {rx_s, rx_sh_q[7:1]};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_sh_q <= '1; tx_bits_q <= '0; tx_tmr_q <= '0; txd_q <= 1'b1;
      rxd_sync_q <= 2'b11; rx_bits_q <= '0; rx_tmr_q <= '0; rx_sh_q <= '0;
      m_data_q <= '0; m_valid_q <= 1'b0; ovr_q <= 1'b0; ferr_q <= 1'b0;
    end else begin
      tx_sh_q <= tx_sh_d; tx_bits_q <= tx_bits_d; tx_tmr_q <= tx_tmr_d; txd_q <= txd_d;
      rxd_sync_q <= {rxd_sync_q[0], rxd};
      rx_bits_q <= rx_bits_d; rx_tmr_q <= rx_tmr_d; rx_sh_q <= rx_sh_d;
      m_data_q <= m_data_d; m_valid_q <= m_valid_d; ovr_q <= ovr_d; ferr_q <= ferr_d;
    end
  end
endmodule

module uart_fifo_peripheral #(
  parameter int          DATA_WIDTH       = 32,
  parameter int          ADDR_WIDTH       = 10,
  parameter int          TX_DEPTH         = 16,
  parameter int          RX_DEPTH         = 16,
  parameter logic [15:0] DEFAULT_PRESCALE = 16'd54
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] slave_data_addr_i,
  input  logic                  slave_data_we_i,
  input  logic [3:0]            slave_data_be_i,
  input  logic [DATA_WIDTH-1:0] slave_data_wdata_i,
  output logic [DATA_WIDTH-1:0] slave_data_rdata_o,
  output logic                  slave_data_rvalid_o,
  output logic                  slave_data_gnt_o,
  input  logic                  data_req_i,
  input  logic                  rxd_uart,
  output logic                  txd_uart,
  output logic                  irq_o
);
  localparam int TAW = $clog2(TX_DEPTH);
  localparam int RAW = $clog2(RX_DEPTH);

  logic [7:0] tx_mem [TX_DEPTH];
  logic [7:0] rx_mem [RX_DEPTH];

  logic [TAW:0]  tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d, tx_cnt;
  logic [RAW:0]  rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d, rx_cnt;
  logic          gnt_q, gnt_d, rvalid_q, rvalid_d, irq_q, irq_d, loop_q, loop_d;
  logic [31:0]   rdata_q, rdata_d, status;
  logic [3:0]    sticky_q, sticky_d, sticky_set, sticky_clr;  // {ovr,ferr,rx_ovf,tx_ovf}
  logic [15:0]   prescale_q, prescale_d;
  logic [2:0]    irq_en_q, irq_en_d;
  logic [7:0]    thresh_q, thresh_d, thr_eff, tx_cnt8, rx_cnt8;
  logic          acc, wr, rd, data_wr, tx_empty, tx_full, rx_empty, rx_full;
  logic          tx_push, tx_pop, rx_push, rx_pop;
  logic [1:0]    sel;
  logic          eng_tready, eng_mvalid, eng_txd, eng_rxd, eng_txb, eng_rxb, eng_ovr, eng_ferr;
  logic [7:0]    eng_mdata;
  logic          unused_bits;

  assign unused_bits = ^{slave_data_addr_i[ADDR_WIDTH-1:4], slave_data_addr_i[1:0],
                         slave_data_wdata_i[DATA_WIDTH-1:17]};

  assign tx_cnt   = tx_wp_q - tx_rp_q;
  assign rx_cnt   = rx_wp_q - rx_rp_q;
  assign tx_empty = (tx_cnt == '0);
  assign tx_full  = (tx_cnt == (TAW+1)'(TX_DEPTH));
  assign rx_empty = (rx_cnt == '0);
  assign rx_full  = (rx_cnt == (RAW+1)'(RX_DEPTH));
  assign tx_cnt8  = 8'(tx_cnt);
  assign rx_cnt8  = 8'(rx_cnt);
  assign thr_eff  = (thresh_q == 8'd0) ? 8'd1 : thresh_q;

  assign status = {rx_cnt8, tx_cnt8, 6'b0, eng_rxb, eng_txb, sticky_q,
                   rx_full, rx_empty, tx_full, tx_empty};

  // Loopback keeps the pin quiet while the engine talks to itself
  assign eng_rxd  = loop_q ? eng_txd : rxd_uart;
  assign txd_uart = loop_q ? 1'b1 : eng_txd;

  assign slave_data_gnt_o    = gnt_q;
  assign slave_data_rvalid_o = rvalid_q;
  assign slave_data_rdata_o  = DATA_WIDTH'(rdata_q);
  assign irq_o               = irq_q;

  always_comb begin
    acc     = data_req_i & ~gnt_q;
    sel     = slave_data_addr_i[3:2];
    wr      = acc & slave_data_we_i;
    rd      = acc & ~slave_data_we_i;
    data_wr = wr & (sel == 2'd0) & slave_data_be_i[0];
    // full/empty come from the pre-edge count, so a push to a full FIFO is
    // dropped even when a pop happens on the same edge
    tx_push = data_wr & ~tx_full;
    tx_pop  = eng_tready & ~tx_empty;
    rx_push = eng_mvalid & ~rx_full;
    rx_pop  = rd & (sel == 2'd0) & ~rx_empty;

    tx_wp_d = tx_wp_q + (TAW+1)'(tx_push);
    tx_rp_d = tx_rp_q + (TAW+1)'(tx_pop);
    rx_wp_d = rx_wp_q + (RAW+1)'(rx_push);
    rx_rp_d = rx_rp_q + (RAW+1)'(rx_pop);

    gnt_d    = acc;
    rvalid_d = acc;
    rdata_d  = '0;
    if (rd) begin
      case (sel)
        2'd0:    rdata_d = rx_empty ? 32'd0 : {1'b1, 23'b0, rx_mem[rx_rp_q[RAW-1:0]]};
        2'd1:    rdata_d = {15'b0, loop_q, prescale_q};
        2'd2:    rdata_d = status;
        default: rdata_d = {16'b0, thresh_q, 5'b0, irq_en_q};
      endcase
    end

    prescale_d = prescale_q;
    loop_d     = loop_q;
    irq_en_d   = irq_en_q;
    thresh_d   = thresh_q;
    if (wr && sel == 2'd1) begin
      if (slave_data_be_i[0]) prescale_d[7:0]  = slave_data_wdata_i[7:0];
      if (slave_data_be_i[1]) prescale_d[15:8] = slave_data_wdata_i[15:8];
      if (slave_data_be_i[2]) loop_d           = slave_data_wdata_i[16];
    end
    if (wr && sel == 2'd3) begin
      if (slave_data_be_i[0]) irq_en_d = slave_data_wdata_i[2:0];
      if (slave_data_be_i[1]) thresh_d = slave_data_wdata_i[15:8];
    end

    // set wins over a same-edge W1C
    sticky_set = {eng_ovr, eng_ferr, eng_mvalid & rx_full, data_wr & tx_full};
    sticky_clr = (wr && sel == 2'd2 && slave_data_be_i[0]) ? slave_data_wdata_i[7:4] : 4'd0;
    sticky_d   = (sticky_q & ~sticky_clr) | sticky_set;

    irq_d = (irq_en_q[0] & (rx_cnt8 >= thr_eff)) | (irq_en_q[1] & tx_empty) |
            (irq_en_q[2] & (|sticky_q));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_wp_q <= '0; tx_rp_q <= '0; rx_wp_q <= '0; rx_rp_q <= '0;
      gnt_q <= 1'b0; rvalid_q <= 1'b0; rdata_q <= '0; irq_q <= 1'b0;
      sticky_q <= '0; prescale_q <= DEFAULT_PRESCALE; loop_q <= 1'b0;
      irq_en_q <= '0; thresh_q <= '0;
    end else begin
      tx_wp_q <= tx_wp_d; tx_rp_q <= tx_rp_d; rx_wp_q <= rx_wp_d; rx_rp_q <= rx_rp_d;
      gnt_q <= gnt_d; rvalid_q <= rvalid_d; rdata_q <= rdata_d; irq_q <= irq_d;
      sticky_q <= sticky_d; prescale_q <= prescale_d; loop_q <= loop_d;
      irq_en_q <= irq_en_d; thresh_q <= thresh_d;
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp_q[TAW-1:0]] <= slave_data_wdata_i[7:0];
    if (rx_push) rx_mem[rx_wp_q[RAW-1:0]] <= eng_mdata;
  end

  axi_uart u_uart (
    .clk              (clk),
    .rst              (~reset),
    .s_axis_tdata     (tx_mem[tx_rp_q[TAW-1:0]]),
    .s_axis_tvalid    (~tx_empty),
    .s_axis_tready    (eng_tready),
    .m_axis_tdata     (eng_mdata),
    .m_axis_tvalid    (eng_mvalid),
    .m_axis_tready    (1'b1),
    .rxd              (eng_rxd),
    .txd              (eng_txd),
    .tx_busy          (eng_txb),
    .rx_busy          (eng_rxb),
    .rx_overrun_error (eng_ovr),
    .rx_frame_error   (eng_ferr),
    .prescale         (prescale_q)
  );
endmodule

// File: tb/tb_uart_fifo_peripheral.sv
// Bench for uart_fifo_peripheral (4-deep FIFOs): register table, randomized
// register and loopback traffic against a queue/byte-merge model, and
// hand-written FIFO overflow, interrupt and reset sequences.
module tb_uart_fifo_peripheral;
  logic        clk = 1'b0, reset = 1'b0, we_i = 1'b0, req = 1'b0, rxd = 1'b1;
  logic [9:0]  addr_i = '0;
  logic [3:0]  be_i = '0;
  logic [31:0] wd_i = '0, rdata;
  logic        rvalid, gnt, txd, irq;
  int          errors = 0, checks = 0;
  bit          mon_en = 0, txd_bad = 0;

  always #5 clk = ~clk;

  uart_fifo_peripheral #(.TX_DEPTH(4), .RX_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .slave_data_addr_i(addr_i), .slave_data_we_i(we_i),
    .slave_data_be_i(be_i), .slave_data_wdata_i(wd_i), .slave_data_rdata_o(rdata),
    .slave_data_rvalid_o(rvalid), .slave_data_gnt_o(gnt), .data_req_i(req),
    .rxd_uart(rxd), .txd_uart(txd), .irq_o(irq));

  always @(negedge clk) if (mon_en && txd !== 1'b1) txd_bad = 1;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic bus(input bit we, input logic [3:0] a, input logic [3:0] be,
                     input logic [31:0] wd, output logic [31:0] rd);
    @(negedge clk);
    req = 1; we_i = we; addr_i = {6'b0, a}; be_i = be; wd_i = wd;
    @(negedge clk);
    rd = rdata;
    chk("bus_handshake", {30'b0, gnt, rvalid}, 32'h3);
    req = 0; we_i = 0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [3:0] be, input logic [31:0] wd);
    logic [31:0] d;
    bus(1, a, be, wd, d);
  endtask

  task automatic rdr(input logic [3:0] a, output logic [31:0] d);
    bus(0, a, 4'hF, 32'd0, d);
  endtask

  // Poll STATUS until rx_count reaches n or the poll budget runs out
  task automatic wait_rx(input int n, input string name);
    logic [31:0] s = '0;
    for (int k = 0; k < 2000; k++) begin
      rdr(4'h8, s);
      if (s[31:24] == 8'(n)) break;
    end
    chk(name, {24'b0, s[31:24]}, 32'(n));
  endtask

  // External 8N1 frame at prescale 4 (32 clocks per bit)
  task automatic send_byte(input logic [7:0] b);
    rxd = 0; repeat (32) @(negedge clk);
    for (int i = 0; i < 8; i++) begin rxd = b[i]; repeat (32) @(negedge clk); end
    rxd = 1; repeat (96) @(negedge clk);
  endtask

  typedef struct {
    bit we; logic [3:0] a; logic [3:0] be; logic [31:0] wd; bit c; logic [31:0] exp;
  } vec_t;

  initial begin
    vec_t        vt[$];
    logic [31:0] d, s, m_cfg, m_irq, mask;
    logic [7:0]  q[$], b, rxb[6];

    vt.push_back('{0, 4'h4, 4'hF, 32'h0,        1, 32'h00000036});
    vt.push_back('{0, 4'h8, 4'hF, 32'h0,        1, 32'h00000005});
    vt.push_back('{0, 4'hC, 4'hF, 32'h0,        1, 32'h00000000});
    vt.push_back('{0, 4'h0, 4'hF, 32'h0,        1, 32'h00000000});
    vt.push_back('{1, 4'h4, 4'h1, 32'hFFFFFF12, 0, 32'h0});
    vt.push_back('{0, 4'h4, 4'hF, 32'h0,        1, 32'h00000012});
    vt.push_back('{1, 4'h4, 4'h2, 32'h0000AB00, 0, 32'h0});
    vt.push_back('{0, 4'h4, 4'hF, 32'h0,        1, 32'h0000AB12});
    vt.push_back('{1, 4'h4, 4'h4, 32'h00010000, 0, 32'h0});
    vt.push_back('{1, 4'h4, 4'h8, 32'hFFFFFFFF, 0, 32'h0});
    vt.push_back('{0, 4'h4, 4'hF, 32'h0,        1, 32'h0001AB12});
    vt.push_back('{1, 4'hC, 4'hF, 32'hFFFFFFFF, 0, 32'h0});
    vt.push_back('{0, 4'hC, 4'hF, 32'h0,        1, 32'h0000FF07});
    vt.push_back('{1, 4'hC, 4'h2, 32'h0,        0, 32'h0});
    vt.push_back('{0, 4'hC, 4'hF, 32'h0,        1, 32'h00000007});
    vt.push_back('{1, 4'hC, 4'h1, 32'h0,        0, 32'h0});
    vt.push_back('{1, 4'h4, 4'hF, 32'h36,       0, 32'h0});
    vt.push_back('{1, 4'h8, 4'h1, 32'hFF,       0, 32'h0});
    vt.push_back('{0, 4'h8, 4'hF, 32'h0,        1, 32'h00000005});

    // reset state
    repeat (3) @(negedge clk);
    chk("reset_outputs", {27'b0, txd, irq, gnt, rvalid, |rdata}, 32'h10);
    reset = 1;
    @(negedge clk);

    // register table
    foreach (vt[i]) begin
      bus(vt[i].we, vt[i].a, vt[i].be, vt[i].wd, d);
      if (vt[i].c) chk($sformatf("vec%0d", i), d, vt[i].exp);
    end

    // held request is accepted every second cycle
    @(negedge clk); req = 1; addr_i = 10'h4; s = 0;
    for (int i = 0; i < 6; i++) begin @(negedge clk); s = {s[30:0], gnt}; end
    req = 0;
    chk("held_req_gnt_pattern", s, 32'b101010);

    // randomized byte-enable writes against a byte-merge model
    m_cfg = 32'h36; m_irq = 0;
    for (int n = 0; n < 24; n++) begin
      logic [3:0] be = 4'($urandom);
      logic [31:0] wd = $urandom;
      bit isc = ($urandom_range(0, 1) == 1);
      mask = 0;
      for (int k = 0; k < 4; k++) if (be[k]) mask[8*k +: 8] = 8'hFF;
      if (isc) m_irq = ((m_irq & ~mask) | (wd & mask)) & 32'h0000FF07;
      else     m_cfg = ((m_cfg & ~mask) | (wd & mask)) & 32'h0001FFFF;
      wr(isc ? 4'hC : 4'h4, be, wd);
      rdr(isc ? 4'hC : 4'h4, d);
      chk(isc ? "rand_irqctrl" : "rand_config", d, isc ? m_irq : m_cfg);
    end
    wr(4'h4, 4'hF, 32'h36); wr(4'hC, 4'hF, 32'h0);

    // loopback, prescale 4
    wr(4'h4, 4'hF, 32'h00010004);
    txd_bad = 0; mon_en = 1;
    wr(4'h0, 4'h1, 32'h41); wr(4'h0, 4'h1, 32'h42); wr(4'h0, 4'h1, 32'h43);
    wait_rx(3, "loopback_rx_count");
    rdr(4'h0, d); chk("loop_rd0", d, 32'h80000041);
    rdr(4'h0, d); chk("loop_rd1", d, 32'h80000042);
    rdr(4'h0, d); chk("loop_rd2", d, 32'h80000043);
    rdr(4'h0, d); chk("loop_rd_empty", d, 32'h0);

    // randomized loopback traffic against a byte queue
    wr(4'h4, 4'hF, 32'h00010002);
    for (int r = 0; r < 4; r++) begin
      int n = $urandom_range(1, 4);
      for (int j = 0; j < n; j++) begin
        b = 8'($urandom); q.push_back(b); wr(4'h0, 4'hF, {24'hFFFFFF, b});
      end
      wait_rx(n, "rand_loop_count");
      for (int j = 0; j < n; j++) begin
        b = q.pop_front(); rdr(4'h0, d); chk("rand_loop_data", d, {1'b1, 23'b0, b});
      end
    end
    mon_en = 0;
    chk("loopback_txd_high", {31'b0, txd_bad}, 32'h0);

    // TX overflow with a slow engine
    wr(4'h4, 4'hF, 32'h0000FFFF);
    for (int i = 0; i < 6; i++) wr(4'h0, 4'h1, 32'h10 + 32'(i));
    rdr(4'h8, s);
    chk("tx_full", {31'b0, s[1]}, 1); chk("tx_ovf", {31'b0, s[4]}, 1);
    chk("tx_count", {24'b0, s[23:16]}, 4);
    wr(4'h8, 4'h1, 32'h10);
    rdr(4'h8, s);
    chk("tx_ovf_w1c", {30'b0, s[4], s[1]}, 32'h1);

    // one-cycle reset with a frame in flight
    @(negedge clk); reset = 0;
    @(negedge clk); chk("txd_in_reset", {31'b0, txd}, 1); reset = 1;
    rdr(4'h8, s); chk("status_after_reset", s, 32'h5);
    rdr(4'h4, d); chk("config_after_reset", d, 32'h36);

    // RX overflow from external frames
    wr(4'h4, 4'hF, 32'h4);
    for (int i = 0; i < 6; i++) begin rxb[i] = 8'($urandom); send_byte(rxb[i]); end
    rdr(4'h8, s); chk("rx_overflow_status", s, 32'h04000029);
    for (int i = 0; i < 4; i++) begin
      rdr(4'h0, d); chk("rx_fifo_order", d, {1'b1, 23'b0, rxb[i]});
    end
    rdr(4'h0, d); chk("rx_empty_read", d, 32'h0);
    wr(4'h8, 4'h1, 32'h20);

    // interrupt threshold
    wr(4'hC, 4'hF, 32'h0201);
    send_byte(8'h55); chk("irq_one_byte", {31'b0, irq}, 0);
    send_byte(8'h66); chk("irq_two_bytes", {31'b0, irq}, 1);
    rdr(4'h0, d); chk("irq_pop_data", d, 32'h80000055);
    @(negedge clk); chk("irq_after_pop", {31'b0, irq}, 0);
    wr(4'hC, 4'hF, 32'h0001);
    @(negedge clk); chk("irq_thresh0_as_1", {31'b0, irq}, 1);
    wr(4'hC, 4'hF, 32'h0002);
    @(negedge clk); chk("irq_tx_empty", {31'b0, irq}, 1);
    wr(4'hC, 4'hF, 32'h0004);
    @(negedge clk); chk("irq_err_none", {31'b0, irq}, 0);
    wr(4'hC, 4'hF, 32'h0);
    rdr(4'h0, d); chk("irq_last_byte", d, 32'h80000066);

    // reset mid-frame with two bytes queued
    wr(4'h0, 4'h1, 32'h5A); wr(4'h0, 4'h1, 32'hA5);
    repeat (100) @(negedge clk);
    reset = 0;
    @(negedge clk); chk("txd_midframe_reset", {31'b0, txd}, 1); reset = 1;
    txd_bad = 0; mon_en = 1;
    rdr(4'h8, s); chk("status_midframe_reset", s, 32'h5);
    rdr(4'h4, d); chk("prescale_midframe_reset", d, 32'h36);
    repeat (400) @(negedge clk);
    mon_en = 0;
    chk("txd_idle_after_flush", {31'b0, txd_bad}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
